mux_sel_sequencer: RTL and testbench

//  Upstream control stage for the alpha/beta/gamma chip-select mux.

---
 rtl/mux_seq_pkg.sv | 15 +
 rtl/rr_pick3.sv | 28 ++
 rtl/mux_sel_sequencer.sv | 99 +++++++++
 tb/tb_mux_sel_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and select encodings for the alpha/beta/gamma mux sequencer.
package mux_seq_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [1:0] SEL_ALPHA = 2'b00;
  localparam logic [1:0] SEL_BETA  = 2'b01;
  localparam logic [1:0] SEL_GAMMA = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search order is last+1, last+2, last (mod 3).
module rr_pick3
  import mux_seq_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_cand;

  // Walk the order backwards so the highest-priority hit is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = SEL_NONE;
    w_cand = SEL_ALPHA;
    for (int k = 3; k >= 1; k--) begin
      w_cand = 2'((int'(last) + k) % 3);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin arbiter driving the mux sel/cs pair; grants last at most
// BURST_LEN acked beats and are separated by at least one idle cycle.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [2:0]       req,
  input  logic             ack,
  output logic [1:0]       sel,
  output logic             cs,
  output logic [2:0]       grant,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  state_t           r_state, w_nxt_state;
  logic [1:0]       r_sel, w_nxt_sel;
  logic [2:0]       r_grant, w_nxt_grant;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [1:0]       r_last, w_nxt_last;

  logic             w_pick_vld;
  logic [1:0]       w_pick_idx;
  logic             w_req_granted;
  logic             w_final_beat;

  rr_pick3 u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  assign w_req_granted = |(req & r_grant);
  assign w_final_beat  = ack && (r_cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_grant = r_grant;
    w_nxt_cnt   = r_cnt;
    w_nxt_last  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_nxt_state = GRANT;
          w_nxt_sel   = w_pick_idx;
          w_nxt_grant = onehot3(w_pick_idx);
          w_nxt_cnt   = '0;
          w_nxt_last  = w_pick_idx;
        end
      end
      GRANT: begin
        // A beat acked on the same edge the request drops still ends the grant.
        if (!w_req_granted || w_final_beat) begin
          w_nxt_state = IDLE;
          w_nxt_sel   = SEL_NONE;
          w_nxt_grant = 3'b000;
          w_nxt_cnt   = '0;
        end else if (ack) begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_sel   = SEL_NONE;
        w_nxt_grant = 3'b000;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_sel   <= SEL_NONE;
      r_grant <= 3'b000;
      r_cnt   <= '0;
      r_last  <= SEL_GAMMA;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_grant <= w_nxt_grant;
      r_cnt   <= w_nxt_cnt;
      r_last  <= w_nxt_last;
    end
  end

  assign sel      = r_sel;
  assign cs       = (r_state == GRANT);
  assign busy     = (r_state == GRANT);
  assign grant    = r_grant;
  assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed table plus reset/burst corner sequences and a random invariant run.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       nReset;
  logic [2:0] req;
  logic       ack;

  logic [1:0] sel;
  logic       cs;
  logic [2:0] grant;
  logic [2:0] beat_cnt;
  logic       busy;

  logic [1:0] sel1;
  logic       cs1;
  logic [2:0] grant1;
  logic [0:0] beat_cnt1;
  logic       busy1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.BURST_LEN(4)) u_dut (
    .clk      (clk),
    .nReset   (nReset),
    .req      (req),
    .ack      (ack),
    .sel      (sel),
    .cs       (cs),
    .grant    (grant),
    .beat_cnt (beat_cnt),
    .busy     (busy)
  );

  mux_sel_sequencer #(.BURST_LEN(1)) u_dut1 (
    .clk      (clk),
    .nReset   (nReset),
    .req      (req),
    .ack      (ack),
    .sel      (sel1),
    .cs       (cs1),
    .grant    (grant1),
    .beat_cnt (beat_cnt1),
    .busy     (busy1)
  );

  typedef struct {
    logic [2:0] req;
    logic       ack;
    logic [1:0] sel;
    logic       cs;
    logic [2:0] grant;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic [2:0] r, input logic a, input logic [1:0] s,
                              input logic c, input logic [2:0] g, input logic [2:0] n);
    vec_t v;
    v.req = r; v.ack = a; v.sel = s; v.cs = c; v.grant = g; v.cnt = n;
    return v;
  endfunction

  function automatic logic [1:0] rr_exp(input logic [2:0] r, input logic [1:0] l);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (int'(l) + k) % 3;
      if (r[c]) return 2'(c);
    end
    return 2'b11;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic chk_out(input string name, input int idx, input logic [1:0] s, input logic c,
                         input logic [2:0] g, input logic [2:0] n);
    chk({name, ".sel"},   idx, 8'(sel),      8'(s));
    chk({name, ".cs"},    idx, 8'(cs),       8'(c));
    chk({name, ".busy"},  idx, 8'(busy),     8'(c));
    chk({name, ".grant"}, idx, 8'(grant),    8'(g));
    chk({name, ".cnt"},   idx, 8'(beat_cnt), 8'(n));
  endtask

  task automatic step(input logic [2:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] req_a, prev_grant;
  logic       ack_a, prev_cs, prev_cs1, exp_cs, inv_ok;
  logic [2:0] prev_cnt;
  logic [1:0] tb_last, win;
  int         waitn[3];

  initial begin
    // alpha burst, re-grant, 3-way rotation, beta short burst ended by req drop
    vecs[0]  = mk(3'b111, 1'b0, 2'b00, 1'b1, 3'b001, 3'd0);
    vecs[1]  = mk(3'b001, 1'b1, 2'b00, 1'b1, 3'b001, 3'd1);
    vecs[2]  = mk(3'b001, 1'b1, 2'b00, 1'b1, 3'b001, 3'd2);
    vecs[3]  = mk(3'b001, 1'b1, 2'b00, 1'b1, 3'b001, 3'd3);
    vecs[4]  = mk(3'b001, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[5]  = mk(3'b001, 1'b1, 2'b00, 1'b1, 3'b001, 3'd0);
    vecs[6]  = mk(3'b111, 1'b1, 2'b00, 1'b1, 3'b001, 3'd1);
    vecs[7]  = mk(3'b111, 1'b1, 2'b00, 1'b1, 3'b001, 3'd2);
    vecs[8]  = mk(3'b111, 1'b1, 2'b00, 1'b1, 3'b001, 3'd3);
    vecs[9]  = mk(3'b111, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[10] = mk(3'b111, 1'b1, 2'b01, 1'b1, 3'b010, 3'd0);
    vecs[11] = mk(3'b111, 1'b1, 2'b01, 1'b1, 3'b010, 3'd1);
    vecs[12] = mk(3'b111, 1'b1, 2'b01, 1'b1, 3'b010, 3'd2);
    vecs[13] = mk(3'b111, 1'b1, 2'b01, 1'b1, 3'b010, 3'd3);
    vecs[14] = mk(3'b111, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[15] = mk(3'b111, 1'b1, 2'b10, 1'b1, 3'b100, 3'd0);
    vecs[16] = mk(3'b111, 1'b1, 2'b10, 1'b1, 3'b100, 3'd1);
    vecs[17] = mk(3'b111, 1'b1, 2'b10, 1'b1, 3'b100, 3'd2);
    vecs[18] = mk(3'b111, 1'b1, 2'b10, 1'b1, 3'b100, 3'd3);
    vecs[19] = mk(3'b111, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[20] = mk(3'b111, 1'b1, 2'b00, 1'b1, 3'b001, 3'd0);
    vecs[21] = mk(3'b010, 1'b0, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[22] = mk(3'b010, 1'b0, 2'b01, 1'b1, 3'b010, 3'd0);
    vecs[23] = mk(3'b010, 1'b1, 2'b01, 1'b1, 3'b010, 3'd1);
    vecs[24] = mk(3'b010, 1'b0, 2'b01, 1'b1, 3'b010, 3'd1);
    vecs[25] = mk(3'b010, 1'b1, 2'b01, 1'b1, 3'b010, 3'd2);
    vecs[26] = mk(3'b000, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[27] = mk(3'b000, 1'b0, 2'b11, 1'b0, 3'b000, 3'd0);
    vecs[28] = mk(3'b000, 1'b1, 2'b11, 1'b0, 3'b000, 3'd0);

    nReset = 1'b0;
    req    = 3'b111;
    ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 2'b11, 1'b0, 3'b000, 3'd0);
    @(negedge clk);
    nReset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].req, vecs[i].ack);
      chk_out("vec", i, vecs[i].sel, vecs[i].cs, vecs[i].grant, vecs[i].cnt);
    end

    // Reset mid-grant at beat_cnt=2; the pointer must return to gamma.
    step(3'b010, 1'b0);
    step(3'b010, 1'b1);
    step(3'b010, 1'b1);
    chk_out("pre_rst", 0, 2'b01, 1'b1, 3'b010, 3'd2);
    nReset = 1'b0;
    #1;
    chk_out("mid_rst", 0, 2'b11, 1'b0, 3'b000, 3'd0);
    req = 3'b110;
    ack = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_rst", 0, 2'b01, 1'b1, 3'b010, 3'd0);
    step(3'b000, 1'b0);
    chk_out("post_rst", 1, 2'b11, 1'b0, 3'b000, 3'd0);
    step(3'b100, 1'b0);
    chk_out("post_rst", 2, 2'b10, 1'b1, 3'b100, 3'd0);
    step(3'b000, 1'b0);
    chk_out("post_rst", 3, 2'b11, 1'b0, 3'b000, 3'd0);

    // BURST_LEN=1: a single acked beat ends the grant.
    step(3'b001, 1'b0);
    chk("b1.grant", 0, 8'(grant1), 8'h01);
    step(3'b001, 1'b1);
    chk("b1.cs", 0, 8'(cs1), 8'h00);
    chk("b1.sel", 0, 8'(sel1), 8'h03);
    chk_out("b4_same", 0, 2'b00, 1'b1, 3'b001, 3'd1);
    step(3'b000, 1'b0);

    tb_last  = 2'd0;
    waitn    = '{0, 0, 0};
    prev_cs  = cs;
    prev_cs1 = cs1;
    prev_grant = grant;
    prev_cnt = beat_cnt;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < 3; b++) req_a[b] = ($urandom_range(3, 0) != 0);
      ack_a = 1'($urandom_range(1, 0));
      step(req_a, ack_a);

      inv_ok = (cs == busy) && ((grant != 3'b000) == cs) && ((sel == 2'b11) == !cs)
               && $onehot0(grant) && (!cs || (grant == (3'b001 << sel)));
      chk("rnd.inv", cyc, 8'(inv_ok), 8'h01);
      chk("rnd.inv1", cyc, 8'((cs1 == busy1) && ((sel1 == 2'b11) == !cs1)), 8'h01);

      if (prev_cs) exp_cs = ((req_a & prev_grant) != 3'b000) && !(ack_a && prev_cnt == 3'd3);
      else         exp_cs = (req_a != 3'b000);
      chk("rnd.cs", cyc, 8'(cs), 8'(exp_cs));

      if (prev_cs && cs) begin
        chk("rnd.hold", cyc, 8'(grant), 8'(prev_grant));
        chk("rnd.cnt", cyc, 8'(beat_cnt), 8'(prev_cnt + 3'(ack_a)));
      end else begin
        chk("rnd.cnt0", cyc, 8'(beat_cnt), 8'h00);
      end

      for (int s = 0; s < 3; s++) if (!req_a[s]) waitn[s] = 0;
      if (!prev_cs && cs) begin
        win = rr_exp(req_a, tb_last);
        chk("rnd.rr", cyc, 8'(sel), 8'(win));
        tb_last = win;
        for (int s = 0; s < 3; s++) begin
          if (s == int'(win)) waitn[s] = 0;
          else if (req_a[s]) waitn[s]++;
          chk("rnd.fair", s, 8'(waitn[s] <= 2), 8'h01);
        end
      end

      chk("rnd.b1cnt", cyc, 8'(beat_cnt1), 8'h00);
      if (prev_cs1 && ack_a) chk("rnd.b1end", cyc, 8'(cs1), 8'h00);

      prev_cs    = cs;
      prev_cs1   = cs1;
      prev_grant = grant;
      prev_cnt   = beat_cnt;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
